program_loader: RTL

Serial program loader for the F100-L soft processor. It accepts a framed byte stream from a UART receiver and assembles big-endian 16-bit words. It writes them sequentially into the 1024-word program RAM that replaces the hardcoded program store, and holds the CPU in reset while a load is in progress. It is the writer side of the program memory: the CPU fetch path only reads what this block has written.

---
 rtl/loader_pkg.sv | 31 +++
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader_word_assembler.sv | 43 ++++
 rtl/program_loader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the F100-L serial program loader: state encoding,
// frame defaults and the program RAM geometry.
package loader_pkg;

  localparam logic [7:0] MAGIC_DEFAULT     = 8'hF1;
  localparam int         MAX_WORDS_DEFAULT = 1024;
  localparam int         ADDR_W            = 10;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_COUNT_HI = 4'd1;
  localparam logic [3:0] ST_COUNT_LO = 4'd2;
  localparam logic [3:0] ST_DATA_HI  = 4'd3;
  localparam logic [3:0] ST_DATA_LO  = 4'd4;
  localparam logic [3:0] ST_WRITE    = 4'd5;
  localparam logic [3:0] ST_CHECKSUM = 4'd6;
  localparam logic [3:0] ST_DONE     = 4'd7;
  localparam logic [3:0] ST_ERROR    = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_COUNT_HI = ST_COUNT_HI,
    S_COUNT_LO = ST_COUNT_LO,
    S_DATA_HI  = ST_DATA_HI,
    S_DATA_LO  = ST_DATA_LO,
    S_WRITE    = ST_WRITE,
    S_CHECKSUM = ST_CHECKSUM,
    S_DONE     = ST_DONE,
    S_ERROR    = ST_ERROR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, program RAM write port and CPU control of the loader.
// master is the loader itself; slave is the UART/RAM/CPU side.
interface program_loader_if;
  import loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_data_out;
  logic              mem_write_enable;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_address, mem_data_out, mem_write_enable,
           cpu_hold, load_done, load_error
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_address, mem_data_out, mem_write_enable,
           cpu_hold, load_done, load_error
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Builds a big-endian 16-bit word from two bytes and keeps the 8-bit
// wrap-around sum of every byte latched since the last clear.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        sel_hi,
  input  logic        latch,
  input  logic        clear,
  output logic [15:0] word,
  output logic [7:0]  sum
);

  logic [15:0] word_q, word_d;
  logic [7:0]  sum_q, sum_d;

  always_comb begin
    word_d = word_q;
    sum_d  = sum_q;
    if (clear) begin
      word_d = 16'h0000;
      sum_d  = 8'h00;
    end else if (latch) begin
      if (sel_hi) word_d[15:8] = byte_in;
      else        word_d[7:0]  = byte_in;
      sum_d = sum_q + byte_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= 16'h0000;
      sum_q  <= 8'h00;
    end else begin
      word_q <= word_d;
      sum_q  <= sum_d;
    end
  end

  assign word = word_q;
  assign sum  = sum_q;

endmodule

// File: rtl/program_loader.sv
// Framed serial loader: MAGIC, 16-bit count, 2*count data bytes, SUM.
// Writes words sequentially into program RAM and holds the CPU while loading.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT,
  parameter int         MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  program_loader_if.master bus
);

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [10:0]       written_q, written_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       count_full;
  logic [10:0]       written_inc;
  logic              asm_latch, asm_sel_hi, asm_clear;
  logic [15:0]       asm_word;
  logic [7:0]        asm_sum;

  assign accept      = bus.rx_valid && rx_ready_q;
  assign count_full  = {count_q[15:8], bus.rx_data};
  assign written_inc = written_q + 11'd1;

  word_assembler u_word_assembler (
    .clk     (clk),
    .reset   (reset),
    .byte_in (bus.rx_data),
    .sel_hi  (asm_sel_hi),
    .latch   (asm_latch),
    .clear   (asm_clear),
    .word    (asm_word),
    .sum     (asm_sum)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    written_d  = written_q;
    we_d       = 1'b0;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    asm_latch  = 1'b0;
    asm_sel_hi = 1'b0;
    asm_clear  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept && bus.rx_data == MAGIC) begin
          state_d   = S_COUNT_HI;
          hold_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          asm_clear = 1'b1;
        end
      end
      S_COUNT_HI: begin
        if (accept) begin
          count_d[15:8] = bus.rx_data;
          state_d       = S_COUNT_LO;
        end
      end
      S_COUNT_LO: begin
        if (accept) begin
          count_d = count_full;
          if (count_full == 16'd0 || count_full > 16'(MAX_WORDS)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            addr_d    = '0;
            written_d = '0;
            state_d   = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          asm_latch  = 1'b1;
          asm_sel_hi = 1'b1;
          state_d    = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          asm_latch = 1'b1;
          we_d      = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // The address holds on the final word so it never wraps past the top.
        written_d = written_inc;
        if (written_inc == count_q[10:0]) begin
          state_d = S_CHECKSUM;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_DATA_HI;
        end
      end
      S_CHECKSUM: begin
        if (accept) begin
          if (bus.rx_data == asm_sum) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = !(state_d == S_WRITE || state_d == S_DONE || state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= 16'd0;
      addr_q     <= '0;
      written_q  <= 11'd0;
      rx_ready_q <= 1'b1;
      we_q       <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      written_q  <= written_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready         = rx_ready_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data_out     = asm_word;
  assign bus.mem_write_enable = we_q;
  assign bus.cpu_hold         = hold_q;
  assign bus.load_done        = done_q;
  assign bus.load_error       = err_q;

endmodule
